// File: rtl/control_pkg.sv
// Shared types for the multicycle controller: FSM state encoding and opcode classes.
package control_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_PCUPD  = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_ALU  = 3'd1,
        CLS_LI   = 3'd2,
        CLS_J    = 3'd3,
        CLS_JZ   = 3'd4,
        CLS_JNZ  = 3'd5,
        CLS_HALT = 3'd6
    } op_class_t;

endpackage

// File: rtl/decod_opcode.sv
// Combinational opcode classifier; only opcode[5:2] selects the class.
module decod_opcode
    import control_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class
);

    logic unused_low_bits;
    assign unused_low_bits = ^opcode[1:0];

    always_comb begin
        op_class = CLS_NOP;
        casez (opcode[5:2])
            4'b0???: op_class = CLS_ALU;
            4'b1000: op_class = CLS_LI;
            4'b1001: op_class = CLS_J;
            4'b1010: op_class = CLS_JZ;
            4'b1011: op_class = CLS_JNZ;
            4'b1111: op_class = CLS_HALT;
            default: op_class = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle datapath controller: FETCH/DECODE/EXEC/PCUPD sequencing with a
// retired-instruction counter. Outputs are decoded from the registered state.
//
// state  | meaning
// INIT   | post-reset idle, one cycle
// FETCH  | load IR when memory ready (stall=0)
// DECODE | latch opcode, branch to HALT or EXEC
// EXEC   | register-file write for ALU/LI, sample z
// PCUPD  | load PC (PC+1 or jump target), retire instruction
// HALT   | program finished, wait for reset
module control_multiciclo
    import control_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             z,
    input  logic             stall,
    output logic             load_ir,
    output logic             load_pc,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic [2:0]       op,
    output logic             fin,
    output logic [CNT_W-1:0] n_instr
);

    state_t           state_q, state_d;
    logic [5:0]       opcode_q, opcode_d;
    logic             z_q, z_d;
    logic [CNT_W-1:0] n_instr_q, n_instr_d;
    logic [5:0]       dec_in;
    op_class_t        op_class;

    // DECODE classifies the live opcode; later states use the latched copy.
    assign dec_in = (state_q == ST_DECODE) ? opcode : opcode_q;

    decod_opcode u_decod (
        .opcode   (dec_in),
        .op_class (op_class)
    );

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        z_d       = z_q;
        n_instr_d = n_instr_q;
        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  if (!stall) state_d = ST_DECODE;
            ST_DECODE: begin
                opcode_d = opcode;
                state_d  = (op_class == CLS_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                z_d     = z;
                state_d = ST_PCUPD;
            end
            ST_PCUPD: begin
                n_instr_d = n_instr_q + CNT_W'(1);
                state_d   = ST_FETCH;
            end
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_INIT;
            opcode_q  <= '0;
            z_q       <= 1'b0;
            n_instr_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            z_q       <= z_d;
            n_instr_q <= n_instr_d;
        end
    end

    always_comb begin
        load_ir = 1'b0;
        load_pc = 1'b0;
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        we3     = 1'b0;
        op      = 3'b000;
        fin     = 1'b0;
        case (state_q)
            ST_FETCH: load_ir = ~stall;
            ST_EXEC: begin
                if (op_class == CLS_ALU) begin
                    we3 = 1'b1;
                    op  = opcode_q[4:2];
                end else if (op_class == CLS_LI) begin
                    we3   = 1'b1;
                    s_inm = 1'b1;
                end
            end
            ST_PCUPD: begin
                load_pc = 1'b1;
                case (op_class)
                    CLS_J:   s_inc = 1'b0;
                    CLS_JZ:  s_inc = ~z_q;
                    CLS_JNZ: s_inc = z_q;
                    default: s_inc = 1'b1;
                endcase
            end
            ST_HALT: fin = 1'b1;
            default: ;
        endcase
    end

    assign n_instr = n_instr_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Randomized self-checking bench: a per-instruction cycle model predicts every output.
module tb_control_multiciclo;

    localparam int CW = 3;
    localparam int C_NOP = 0, C_ALU = 1, C_LI = 2, C_J = 3, C_JZ = 4, C_JNZ = 5, C_HALT = 6;

    logic          clk, reset, z, stall;
    logic [5:0]    opcode;
    logic          load_ir, load_pc, s_inc, s_inm, we3, fin;
    logic [2:0]    op;
    logic [CW-1:0] n_instr;

    int tests = 0;
    int fails = 0;
    int n_model = 0;

    control_multiciclo #(.CNT_W(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .opcode  (opcode),
        .z       (z),
        .stall   (stall),
        .load_ir (load_ir),
        .load_pc (load_pc),
        .s_inc   (s_inc),
        .s_inm   (s_inm),
        .we3     (we3),
        .op      (op),
        .fin     (fin),
        .n_instr (n_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cls_of(input logic [5:0] oc);
        logic [3:0] k;
        k = oc[5:2];
        if (k < 4'd8)  return C_ALU;
        if (k == 4'd8)  return C_LI;
        if (k == 4'd9)  return C_J;
        if (k == 4'd10) return C_JZ;
        if (k == 4'd11) return C_JNZ;
        if (k == 4'd15) return C_HALT;
        return C_NOP;
    endfunction

    // {load_ir, load_pc, s_inc, s_inm, we3, op[2:0], fin}
    function automatic logic [8:0] mk(input logic li, input logic lp, input logic si,
                                      input logic sm, input logic we, input logic [2:0] o,
                                      input logic f);
        return {li, lp, si, sm, we, o, f};
    endfunction

    localparam logic [8:0] IDLE = 9'b0_0_1_0_0_000_0;

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0]    obs;
        logic [CW-1:0] exp_n;
        obs   = {load_ir, load_pc, s_inc, s_inm, we3, op, fin};
        exp_n = CW'(n_model);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp);
        end
        tests++;
        assert (n_instr === exp_n) else begin
            fails++;
            $error("FAIL %s n_instr observed=%0d expected=%0d", tag, n_instr, exp_n);
        end
    endtask

    task automatic cyc(input logic st, input logic [5:0] oc, input logic zz,
                       input logic [8:0] exp, input string tag);
        stall  = st;
        opcode = oc;
        z      = zz;
        #1;
        chk(tag, exp);
        @(negedge clk);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] ro();
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic fetch_decode(input logic [5:0] oc, input int nstall);
        for (int i = 0; i < nstall; i++) cyc(1'b1, ro(), rb(), IDLE, "fetch_stall");
        cyc(1'b0, ro(), rb(), mk(1, 0, 1, 0, 0, 3'b000, 0), "fetch");
        cyc(rb(), oc, rb(), IDLE, "decode");
    endtask

    task automatic run_instr(input logic [5:0] oc, input int nstall, input logic zexec);
        int         c;
        logic       taken;
        logic [8:0] e_exec;
        c = cls_of(oc);
        if (c == C_ALU)     e_exec = mk(0, 0, 1, 0, 1, oc[4:2], 0);
        else if (c == C_LI) e_exec = mk(0, 0, 1, 1, 1, 3'b000, 0);
        else                e_exec = IDLE;
        taken = (c == C_J) || (c == C_JZ && zexec) || (c == C_JNZ && !zexec);
        fetch_decode(oc, nstall);
        cyc(rb(), ro(), zexec, e_exec, "exec");
        cyc(rb(), ro(), rb(), mk(0, 1, ~taken, 0, 0, 3'b000, 0), "pcupd");
        n_model = (n_model + 1) % (1 << CW);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("reset_async", IDLE);
        @(negedge clk);
        chk("reset_hold", IDLE);
        reset = 1'b0;
        #1;
        chk("init", IDLE);
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] oc;
        reset  = 1'b1;
        stall  = 1'b0;
        opcode = 6'd0;
        z      = 1'b0;
        @(negedge clk);
        n_model = 0;
        chk("reset_state", IDLE);
        @(negedge clk);
        chk("reset_state2", IDLE);
        reset = 1'b0;
        #1;
        chk("init", IDLE);
        @(negedge clk);

        run_instr(6'b000100, 0, rb());
        run_instr(6'b100000, 0, rb());
        run_instr(6'b101000, 0, 1'b1);
        run_instr(6'b101000, 0, 1'b0);
        run_instr(6'b000000, 3, rb());
        run_instr(6'b100100, 0, rb());
        run_instr(6'b101100, 1, 1'b0);
        run_instr(6'b101100, 0, 1'b1);
        run_instr(6'b110000, 2, rb());

        for (int i = 0; i < 40; i++) begin
            do oc = ro(); while (cls_of(oc) == C_HALT);
            run_instr(oc, $urandom_range(0, 3), rb());
        end

        fetch_decode(6'b111100, 1);
        for (int i = 0; i < 20; i++)
            cyc(rb(), ro(), rb(), mk(0, 0, 1, 0, 0, 3'b000, 1), "halt");
        n_model = 0;
        do_reset();

        run_instr(6'b011000, 0, rb());
        run_instr(6'b100000, 0, rb());
        fetch_decode(6'b010100, 0);
        stall  = rb();
        opcode = ro();
        z      = rb();
        #1;
        chk("exec_before_reset", mk(0, 0, 1, 0, 1, 3'b101, 0));
        n_model = 0;
        do_reset();
        run_instr(6'b001100, 0, rb());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_multiciclo.md
CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  6  current instruction opcode from the datapath instruction register.
REQ-005 z  in  1  ALU zero flag from the datapath.
REQ-006 stall  in  1  instruction memory not ready; holds FETCH.
REQ-007 load_ir  out  1  instruction register load enable.
REQ-008 load_pc  out  1  program counter load enable.
REQ-009 s_inc  out  1  PC source: 1 = PC+1, 0 = jump target.
REQ-010 s_inm  out  1  register-file write source: 1 = immediate, 0 = ALU.
REQ-011 we3  out  1  register-file write enable.
REQ-012 op  out  3  ALU operation select.
REQ-013 fin  out  1  program halted.
REQ-014 n_instr  out  CNT_W  count of retired instructions.

Function
REQ-015 The FSM SHALL have the states INIT, FETCH, DECODE, EXEC, PCUPD and HALT.
REQ-016 Transitions SHALL be: INIT->FETCH; FETCH->DECODE when stall=0, else stay; DECODE->HALT if opcode is HALT, else EXEC; EXEC->PCUPD; PCUPD->FETCH; HALT->HALT.
REQ-017 load_ir SHALL be 1 only in FETCH with stall=0.
REQ-018 In DECODE the block SHALL latch opcode into opcode_q; EXEC and PCUPD SHALL decode opcode_q only.
REQ-019 Decoding SHALL use opcode_q[5:2]: 0xxx ALU (op=opcode_q[4:2]); 1000 LI; 1001 J; 1010 JZ; 1011 JNZ; 1111 HALT; others NOP.
REQ-020 In EXEC, ALU SHALL drive we3=1, s_inm=0, op=opcode_q[4:2]; LI SHALL drive we3=1, s_inm=1; all other classes SHALL drive we3=0.
REQ-021 z SHALL be sampled into z_q on the clk edge leaving EXEC.
REQ-022 In PCUPD, load_pc SHALL be 1, and s_inc SHALL be 0 for J, for JZ with z_q=1 and for JNZ with z_q=0, else 1.
REQ-023 n_instr SHALL increment by 1 on each edge leaving PCUPD and wrap from all-ones to 0.
REQ-024 In HALT, fin SHALL be 1 and load_ir, load_pc and we3 SHALL be 0; HALT SHALL NOT increment n_instr.
REQ-025 Outside the states named above, outputs SHALL be 0, except s_inc=1 and op=3'b000.
REQ-026 Latency SHALL be 4 cycles per non-halt instruction with stall=0, plus 1 cycle per stalled FETCH cycle.
REQ-027 stall SHALL be ignored in every state except FETCH.

Reset
REQ-028 While reset=1 the state SHALL be INIT; opcode_q, z_q and n_instr SHALL be 0; fin, we3, load_ir, load_pc and s_inm SHALL be 0; s_inc SHALL be 1; op SHALL be 0.
REQ-029 Reset asserted in any state, including HALT or mid-instruction, SHALL take effect immediately and without any partial register write or PC load.
REQ-030 The first FETCH SHALL occur one cycle after reset deasserts.

Structure
REQ-031 The state encoding and the opcode-class constants (ALU, LI, J, JZ, JNZ, HALT) SHALL be in the shared package control_pkg.
REQ-032 Opcode classification SHALL be a combinational sub-module decod_opcode (input opcode[5:0], output class), instantiated once.

Verification
REQ-033 Reset, then ALU opcode 6'b000100 with stall=0 -> load_ir in cycle 2, we3=1 and op=3'b001 in cycle 4, load_pc=1 and s_inc=1 in cycle 5, n_instr=1.
REQ-034 LI opcode 6'b100000 -> we3=1 and s_inm=1 in EXEC; s_inc=1 in PCUPD.
REQ-035 JZ opcode 6'b101000 with z=1 in EXEC -> s_inc=0 in PCUPD; repeat with z=0 -> s_inc=1.
REQ-036 stall=1 for 3 cycles in FETCH -> FETCH held 3 extra cycles with load_ir=0, then load_ir=1 for exactly 1 cycle.
REQ-037 HALT opcode 6'b111100 -> fin=1 from the cycle after DECODE, n_instr frozen for 20 cycles; reset -> fin=0 and INIT.
REQ-038 Reset asserted during EXEC of an ALU op -> we3 drops in the same cycle, no load_pc, n_instr=0.
